lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: accepts one operation from exu, performs at most one memory
// request with lane masking / load extension, and holds the result for wbu.
module lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_sys_valid,
    output logic                  o_sys_ready,
    output logic                  o_sys_valid,
    input  logic                  i_sys_ready,
    input  logic                  i_idu_ctr_ram_rd_en,
    input  logic                  i_idu_ctr_ram_wr_en,
    input  logic [2:0]            i_idu_ctr_ram_byt,
    input  logic [DATA_WIDTH-1:0] i_exu_res,
    input  logic [DATA_WIDTH-1:0] i_gpr_rs2_data,
    output logic                  o_ram_req,
    input  logic                  i_ram_ack,
    output logic                  o_ram_wr_en,
    output logic [DATA_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wr_data,
    output logic [3:0]            o_ram_wr_mask,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
    output logic [DATA_WIDTH-1:0] o_lsu_ram_res,
    output logic                  o_lsu_misalign,
    output logic [1:0]            o_lsu_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both 1; valid never waits for ready, and payload is held while valid && !ready.
    // The memory side is req/ack: o_ram_req stays high, with stable payload,
    // up to and including the cycle i_ram_ack is seen.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    function automatic size_t decode_size(input logic [2:0] byt);
        case (byt)
            3'b000, 3'b100: decode_size = SZ_BYTE;
            3'b001, 3'b101: decode_size = SZ_HALF;
            default:        decode_size = SZ_WORD;
        endcase
    endfunction

    state_t                state;
    state_t                state_nxt;

    logic                  accept;
    size_t                 in_size;
    logic                  in_mem;
    logic                  in_mis;

    logic [DATA_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] rs2_r;
    size_t                 size_r;
    logic                  uns_r;
    logic                  store_r;
    logic                  mis_r;
    logic [DATA_WIDTH-1:0] res_r;

    logic [3:0]            lane_mask;
    logic [DATA_WIDTH-1:0] ld_shift;
    logic [DATA_WIDTH-1:0] ld_ext;

    // Decode of the operation presented at the input, used only at accept.
    assign accept  = i_sys_valid && (state == S_IDLE);
    assign in_size = decode_size(i_idu_ctr_ram_byt);
    assign in_mem  = i_idu_ctr_ram_rd_en || i_idu_ctr_ram_wr_en;
    assign in_mis  = in_mem &&
                     (((in_size == SZ_HALF) && i_exu_res[0]) ||
                      ((in_size == SZ_WORD) && (i_exu_res[1:0] != 2'b00)));

    // State register
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (in_mem && !in_mis) ? S_REQ : S_RESP;
                end
            end
            S_REQ: begin
                if (i_ram_ack) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (i_sys_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operation capture; a store wins when both enables are set.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            addr_r  <= '0;
            rs2_r   <= '0;
            size_r  <= SZ_WORD;
            uns_r   <= 1'b0;
            store_r <= 1'b0;
            mis_r   <= 1'b0;
            res_r   <= '0;
        end else if (accept) begin
            addr_r  <= i_exu_res;
            rs2_r   <= i_gpr_rs2_data;
            size_r  <= in_size;
            uns_r   <= i_idu_ctr_ram_byt[2];
            store_r <= i_idu_ctr_ram_wr_en;
            mis_r   <= in_mis;
            res_r   <= '0;
        end else if ((state == S_REQ) && i_ram_ack && !store_r) begin
            res_r   <= ld_ext;
        end
    end

    // Lane placement for stores
    always_comb begin
        lane_mask     = 4'b1111;
        o_ram_wr_data = rs2_r;
        case (size_r)
            SZ_BYTE: begin
                lane_mask     = 4'b0001 << addr_r[1:0];
                o_ram_wr_data = {(DATA_WIDTH/8){rs2_r[7:0]}};
            end
            SZ_HALF: begin
                lane_mask     = 4'b0011 << addr_r[1:0];
                o_ram_wr_data = {(DATA_WIDTH/16){rs2_r[15:0]}};
            end
            default: begin
                lane_mask     = 4'b1111;
                o_ram_wr_data = rs2_r;
            end
        endcase
    end

    // Load lane select and extension; aligned halves sit at offset 0 or 2.
    assign ld_shift = i_ram_rd_data >> {addr_r[1:0], 3'b000};

    always_comb begin
        ld_ext = ld_shift;
        case (size_r)
            SZ_BYTE: ld_ext = uns_r ? {{(DATA_WIDTH-8){1'b0}}, ld_shift[7:0]}
                                    : {{(DATA_WIDTH-8){ld_shift[7]}}, ld_shift[7:0]};
            SZ_HALF: ld_ext = uns_r ? {{(DATA_WIDTH-16){1'b0}}, ld_shift[15:0]}
                                    : {{(DATA_WIDTH-16){ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = i_ram_rd_data;
        endcase
    end

    // Output logic
    always_comb begin
        o_sys_ready    = 1'b0;
        o_sys_valid    = 1'b0;
        o_ram_req      = 1'b0;
        o_ram_wr_en    = 1'b0;
        o_ram_wr_mask  = 4'b0000;
        o_lsu_misalign = 1'b0;
        case (state)
            S_IDLE: o_sys_ready = 1'b1;
            S_REQ: begin
                o_ram_req     = 1'b1;
                o_ram_wr_en   = store_r;
                o_ram_wr_mask = store_r ? lane_mask : 4'b0000;
            end
            S_RESP: begin
                o_sys_valid    = 1'b1;
                o_lsu_misalign = mis_r;
            end
            default: ;
        endcase
    end

    assign o_ram_addr    = {addr_r[DATA_WIDTH-1:2], 2'b00};
    assign o_lsu_ram_res = res_r;
    assign o_lsu_state   = state;

endmodule
